// File: rtl/per_addr_demux_pkg.sv
// Shared definitions for the peripheral address demux: response opcodes and
// address-region rules with a containment helper.
package per_demux_pkg;

    localparam logic PER_OPC_OK  = 1'b0;
    localparam logic PER_OPC_ERR = 1'b1;

    // Rules are held at the widest supported address so one type serves any ADDR_WIDTH <= 64.
    typedef struct packed {
        logic [63:0] start_addr;
        logic [63:0] end_addr;
    } addr_rule_t;

    function automatic logic addr_match(input addr_rule_t rule, input logic [63:0] addr);
        return (addr >= rule.start_addr) && (addr < rule.end_addr);
    endfunction

endpackage

// File: rtl/per_addr_demux_if.sv
// Bundle of the upstream TCDM-style port and the fanned-out peripheral ports.
// 'slave' is the demux's own view; 'master' is the surrounding environment's view.
interface per_addr_demux_if #(
    parameter int NB_SLAVES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
);
    logic                                 per_slave_req_i;
    logic [ADDR_WIDTH-1:0]                per_slave_add_i;
    logic                                 per_slave_we_ni;
    logic [DATA_WIDTH-1:0]                per_slave_wdata_i;
    logic [BE_WIDTH-1:0]                  per_slave_be_i;
    logic                                 per_slave_gnt_o;
    logic                                 per_slave_r_valid_o;
    logic                                 per_slave_r_opc_o;
    logic [DATA_WIDTH-1:0]                per_slave_r_rdata_o;

    logic [NB_SLAVES-1:0]                 per_master_req_o;
    logic [ADDR_WIDTH-1:0]                per_master_add_o;
    logic                                 per_master_we_no;
    logic [DATA_WIDTH-1:0]                per_master_wdata_o;
    logic [BE_WIDTH-1:0]                  per_master_be_o;
    logic [NB_SLAVES-1:0]                 per_master_gnt_i;
    logic [NB_SLAVES-1:0]                 per_master_r_valid_i;
    logic [NB_SLAVES-1:0]                 per_master_r_opc_i;
    logic [NB_SLAVES-1:0][DATA_WIDTH-1:0] per_master_r_rdata_i;

    modport slave (
        input  per_slave_req_i, per_slave_add_i, per_slave_we_ni, per_slave_wdata_i, per_slave_be_i,
        output per_slave_gnt_o, per_slave_r_valid_o, per_slave_r_opc_o, per_slave_r_rdata_o,
        output per_master_req_o, per_master_add_o, per_master_we_no, per_master_wdata_o, per_master_be_o,
        input  per_master_gnt_i, per_master_r_valid_i, per_master_r_opc_i, per_master_r_rdata_i
    );

    modport master (
        output per_slave_req_i, per_slave_add_i, per_slave_we_ni, per_slave_wdata_i, per_slave_be_i,
        input  per_slave_gnt_o, per_slave_r_valid_o, per_slave_r_opc_o, per_slave_r_rdata_o,
        input  per_master_req_o, per_master_add_o, per_master_we_no, per_master_wdata_o, per_master_be_o,
        output per_master_gnt_i, per_master_r_valid_i, per_master_r_opc_i, per_master_r_rdata_i
    );

endinterface

// File: rtl/per_addr_demux_chk.sv
// Protocol checks for the demux: stray slave responses and grants at the outstanding limit.
module per_addr_demux_chk #(
    parameter int NB_SLAVES = 4,
    parameter int TGT_W     = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    input logic                 out_cnt_zero_i,
    input logic                 out_cnt_full_i,
    input logic                 issue_i,
    input logic [TGT_W-1:0]     cur_tgt_i,
    input logic [NB_SLAVES-1:0] r_valid_i
);

    logic [NB_SLAVES-1:0] cur_mask_s;
    assign cur_mask_s = {{(NB_SLAVES-1){1'b0}}, 1'b1} << cur_tgt_i;

    // Stray responses are legal to drop (e.g. after a reset), so they are reported, not fatal.
    a_no_stray_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        out_cnt_zero_i ? (r_valid_i == '0) : ((r_valid_i & ~cur_mask_s) == '0))
        else $warning("per_addr_demux: slave response ignored (not current target or nothing outstanding)");

    a_no_issue_at_limit: assert property (@(posedge clk_i) disable iff (rst_i)
        !(issue_i && out_cnt_full_i))
        else $error("per_addr_demux: grant issued with outstanding count at limit");

endmodule

// File: rtl/per_addr_demux_decode.sv
// Combinational address decoder: reports whether the address hits any slave region
// and, if so, the lowest-indexed matching slave.
module per_addr_decode
    import per_demux_pkg::*;
#(
    parameter int NB_SLAVES  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] END_ADDR   = '0,
    localparam int TGT_W = $clog2(NB_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0] add_i,
    output logic                  match_o,
    output logic [TGT_W-1:0]      tgt_o
);

    // Walk from the highest index down so the lowest matching index is the last one written.
    always_comb begin
        addr_rule_t rule_v;
        logic       hit_v;
        match_o = 1'b0;
        tgt_o   = '0;
        rule_v  = '0;
        hit_v   = 1'b0;
        for (int i = NB_SLAVES - 1; i >= 0; i--) begin
            rule_v.start_addr = 64'(START_ADDR[i]);
            rule_v.end_addr   = 64'(END_ADDR[i]);
            hit_v             = addr_match(rule_v, 64'(add_i));
            match_o           = match_o | hit_v;
            tgt_o             = hit_v ? TGT_W'(i) : tgt_o;
        end
    end

endmodule

// File: rtl/per_addr_demux.sv
// Routes one request stream to NB_SLAVES peripherals by address and returns
// their responses in order; unmapped accesses receive a one-cycle error response.
module per_addr_demux
    import per_demux_pkg::*;
#(
    parameter int NB_SLAVES       = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] START_ADDR =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [NB_SLAVES-1:0][ADDR_WIDTH-1:0] END_ADDR =
        {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    localparam int TGT_W = $clog2(NB_SLAVES),
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    per_addr_demux_if.slave         bus,
    output logic                    busy_o
);

    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [TGT_W-1:0] cur_tgt_q, cur_tgt_d;
    logic             err_pend_q, err_pend_d;

    logic             match_s;
    logic [TGT_W-1:0] tgt_s;
    logic             gate_open_s;
    logic             issue_s;
    logic             err_issue_s;
    logic             rsp_s;

    per_addr_decode #(
        .NB_SLAVES  (NB_SLAVES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .START_ADDR (START_ADDR),
        .END_ADDR   (END_ADDR)
    ) u_decode (
        .add_i   (bus.per_slave_add_i),
        .match_o (match_s),
        .tgt_o   (tgt_s)
    );

    assign bus.per_master_add_o   = bus.per_slave_add_i;
    assign bus.per_master_we_no   = bus.per_slave_we_ni;
    assign bus.per_master_wdata_o = bus.per_slave_wdata_i;
    assign bus.per_master_be_o    = bus.per_slave_be_i;

    // Keeping a single target in flight is what guarantees in-order responses.
    assign gate_open_s = !err_pend_q &&
                         ((out_cnt_q == '0) ||
                          ((tgt_s == cur_tgt_q) && (out_cnt_q < CNT_W'(MAX_OUTSTANDING))));

    // Request routing and upstream grant.
    always_comb begin
        bus.per_master_req_o = '0;
        bus.per_slave_gnt_o  = 1'b0;
        issue_s              = 1'b0;
        err_issue_s          = 1'b0;
        if (!rst_i && bus.per_slave_req_i) begin
            if (match_s) begin
                if (gate_open_s) begin
                    bus.per_master_req_o[tgt_s] = 1'b1;
                    bus.per_slave_gnt_o         = bus.per_master_gnt_i[tgt_s];
                    issue_s                     = bus.per_master_gnt_i[tgt_s];
                end else begin
                    bus.per_slave_gnt_o = 1'b0;
                end
            end else begin
                if ((out_cnt_q == '0) && !err_pend_q) begin
                    bus.per_slave_gnt_o = 1'b1;
                    err_issue_s         = 1'b1;
                end else begin
                    bus.per_slave_gnt_o = 1'b0;
                end
            end
        end else begin
            bus.per_slave_gnt_o = 1'b0;
        end
    end

    assign rsp_s = !rst_i && (out_cnt_q != '0) && bus.per_master_r_valid_i[cur_tgt_q];

    // Response merge; an error response cannot coincide with a slave one since out_cnt is 0 then.
    always_comb begin
        bus.per_slave_r_valid_o = 1'b0;
        bus.per_slave_r_opc_o   = PER_OPC_OK;
        bus.per_slave_r_rdata_o = '0;
        if (rst_i) begin
            bus.per_slave_r_valid_o = 1'b0;
        end else if (err_pend_q) begin
            bus.per_slave_r_valid_o = 1'b1;
            bus.per_slave_r_opc_o   = PER_OPC_ERR;
        end else if (rsp_s) begin
            bus.per_slave_r_valid_o = 1'b1;
            bus.per_slave_r_opc_o   = bus.per_master_r_opc_i[cur_tgt_q];
            bus.per_slave_r_rdata_o = bus.per_master_r_rdata_i[cur_tgt_q];
        end else begin
            bus.per_slave_r_valid_o = 1'b0;
        end
    end

    assign busy_o = !rst_i && ((out_cnt_q != '0) || err_pend_q);

    // Next-state: target follows each grant, counter nets grants against responses.
    always_comb begin
        cur_tgt_d  = issue_s ? tgt_s : cur_tgt_q;
        err_pend_d = err_issue_s;
        case ({issue_s, rsp_s})
            2'b10:   out_cnt_d = out_cnt_q + CNT_W'(1);
            2'b01:   out_cnt_d = out_cnt_q - CNT_W'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_cnt_q  <= '0;
            cur_tgt_q  <= '0;
            err_pend_q <= 1'b0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            cur_tgt_q  <= cur_tgt_d;
            err_pend_q <= err_pend_d;
        end
    end

    per_addr_demux_chk #(
        .NB_SLAVES (NB_SLAVES),
        .TGT_W     (TGT_W)
    ) u_chk (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .out_cnt_zero_i (out_cnt_q == '0),
        .out_cnt_full_i (out_cnt_q == CNT_W'(MAX_OUTSTANDING)),
        .issue_i        (issue_s),
        .cur_tgt_i      (cur_tgt_q),
        .r_valid_i      (bus.per_master_r_valid_i)
    );

endmodule

// File: tb/tb_per_addr_demux.sv
// Bench for per_addr_demux: directed sequences, a vector table, and random traffic
// against a queue-based reference model. Slave 1's region overlaps slave 0's upper half.
module tb_per_addr_demux;

    localparam int NB  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MAX = 2;
    localparam logic [NB-1:0][AW-1:0] P_START =
        {32'h3000_0000, 32'h2000_0000, 32'h0800_0000, 32'h0000_0000};
    localparam logic [NB-1:0][AW-1:0] P_END =
        {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000};

    logic [31:0] reg_lo [NB] = '{32'h0000_0000, 32'h0800_0000, 32'h2000_0000, 32'h3000_0000};
    logic [31:0] reg_hi [NB] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    per_addr_demux_if #(.NB_SLAVES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    per_addr_demux #(
        .NB_SLAVES(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX),
        .START_ADDR(P_START), .END_ADDR(P_END)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  gnt_in;
        logic [3:0]  exp_req;
        logic        exp_gnt;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.per_slave_req_i      = 1'b0;
        bus.per_slave_add_i      = '0;
        bus.per_slave_we_ni      = 1'b1;
        bus.per_slave_wdata_i    = '0;
        bus.per_slave_be_i       = '0;
        bus.per_master_gnt_i     = '0;
        bus.per_master_r_valid_i = '0;
        bus.per_master_r_opc_i   = '0;
        bus.per_master_r_rdata_i = '0;
    endtask

    task automatic req(input logic [31:0] a, input logic we_n, input logic [3:0] g);
        bus.per_slave_req_i   = 1'b1;
        bus.per_slave_add_i   = a;
        bus.per_slave_we_ni   = we_n;
        bus.per_slave_wdata_i = $urandom();
        bus.per_slave_be_i    = 4'hF;
        bus.per_master_gnt_i  = g;
    endtask

    // Reference decode: first region (lowest index) that contains the address.
    function automatic bit ref_dec(input logic [31:0] a, output int t);
        t = 0;
        for (int i = 0; i < NB; i++) begin
            if (a >= reg_lo[i] && a < reg_hi[i]) begin
                t = i;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    vec_t tbl [9];

    initial begin
        int          inflight[$];
        int          slq[NB][$];
        bit          err_m, held, held_we, m, nerr;
        logic [31:0] held_addr;
        logic [3:0]  ereq;
        logic        egnt, erv, eopc;
        logic [31:0] erd;
        int          t, r;

        tbl[0] = '{32'h0000_0040, 4'b1111, 4'b0001, 1'b1, 1'b0};
        tbl[1] = '{32'h0800_0010, 4'b1111, 4'b0001, 1'b1, 1'b0};
        tbl[2] = '{32'h0FFF_FFFC, 4'b0010, 4'b0001, 1'b0, 1'b0};
        tbl[3] = '{32'h1000_0000, 4'b1111, 4'b0010, 1'b1, 1'b0};
        tbl[4] = '{32'h1FFF_FFFF, 4'b1101, 4'b0010, 1'b0, 1'b0};
        tbl[5] = '{32'h2000_0000, 4'b1111, 4'b0100, 1'b1, 1'b0};
        tbl[6] = '{32'h3FFF_FFFF, 4'b1111, 4'b1000, 1'b1, 1'b0};
        tbl[7] = '{32'h4000_0000, 4'b1111, 4'b0000, 1'b1, 1'b1};
        tbl[8] = '{32'hFFFF_FFFF, 4'b0000, 4'b0000, 1'b1, 1'b1};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        // Reset: outputs must be quiet even with an unmapped request presented.
        req(32'hFFFF_0000, 1'b1, 4'b1111);
        #3;
        chk("rst_gnt", bus.per_slave_gnt_o, 1'b0);
        chk("rst_rvalid", bus.per_slave_r_valid_o, 1'b0);
        chk("rst_opc", bus.per_slave_r_opc_o, 1'b0);
        chk("rst_rdata", bus.per_slave_r_rdata_o, 32'h0);
        chk("rst_req", bus.per_master_req_o, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        tick();
        rst = 1'b0;
        idle_inputs();
        tick();

        // 1: read to slave 1, response two cycles later.
        req(32'h1000_0010, 1'b1, 4'b0010);
        #3; chk("t1_gnt", bus.per_slave_gnt_o, 1'b1); chk("t1_req", bus.per_master_req_o, 4'b0010);
        tick(); idle_inputs();
        #3; chk("t1_rv_c1", bus.per_slave_r_valid_o, 1'b0); chk("t1_busy", busy, 1'b1);
        tick();
        bus.per_master_r_valid_i = 4'b0010;
        bus.per_master_r_rdata_i[1] = 32'hCAFE_F00D;
        #3; chk("t1_rv", bus.per_slave_r_valid_o, 1'b1);
        chk("t1_rdata", bus.per_slave_r_rdata_o, 32'hCAFE_F00D);
        chk("t1_opc", bus.per_slave_r_opc_o, 1'b0);
        tick(); idle_inputs();
        #3; chk("t1_idle", busy, 1'b0);
        tick();

        // 2: back-to-back writes to slave 0; third stalls until the first response.
        req(32'h0000_0100, 1'b0, 4'b1111);
        #3; chk("t2_gnt0", bus.per_slave_gnt_o, 1'b1);
        tick(); req(32'h0000_0104, 1'b0, 4'b1111);
        #3; chk("t2_gnt1", bus.per_slave_gnt_o, 1'b1);
        tick(); req(32'h0000_0108, 1'b0, 4'b1111);
        #3; chk("t2_stall_gnt", bus.per_slave_gnt_o, 1'b0); chk("t2_stall_req", bus.per_master_req_o, 4'b0000);
        tick();
        #3; chk("t2_stall2", bus.per_slave_gnt_o, 1'b0);
        tick(); bus.per_master_r_valid_i = 4'b0001;
        #3; chk("t2_rv1", bus.per_slave_r_valid_o, 1'b1); chk("t2_gnt_rsp", bus.per_slave_gnt_o, 1'b0);
        tick(); bus.per_master_r_valid_i = 4'b0000;
        #3; chk("t2_gnt2", bus.per_slave_gnt_o, 1'b1); chk("t2_req2", bus.per_master_req_o, 4'b0001);
        tick(); idle_inputs(); bus.per_master_r_valid_i = 4'b0001;
        #3; chk("t2_rv2", bus.per_slave_r_valid_o, 1'b1);
        tick();
        #3; chk("t2_rv3", bus.per_slave_r_valid_o, 1'b1);
        tick(); idle_inputs();
        #3; chk("t2_idle", busy, 1'b0);
        tick();

        // 3: target switch waits for slave 0's delayed response.
        req(32'h0000_0200, 1'b0, 4'b1111);
        #3; chk("t3_gnt0", bus.per_slave_gnt_o, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            tick(); req(32'h2000_0000, 1'b1, 4'b1111);
            bus.per_master_r_valid_i = (c == 5) ? 4'b0001 : 4'b0000;
            #3; chk("t3_hold_req", bus.per_master_req_o, 4'b0000); chk("t3_hold_gnt", bus.per_slave_gnt_o, 1'b0);
        end
        chk("t3_rv0", bus.per_slave_r_valid_o, 1'b1);
        tick(); bus.per_master_r_valid_i = 4'b0000;
        #3; chk("t3_req2", bus.per_master_req_o, 4'b0100); chk("t3_gnt2", bus.per_slave_gnt_o, 1'b1);
        tick(); idle_inputs(); bus.per_master_r_valid_i = 4'b0100;
        #3; chk("t3_rv2", bus.per_slave_r_valid_o, 1'b1);
        tick(); idle_inputs();
        #3; chk("t3_idle", busy, 1'b0);
        tick();

        // 4: unmapped access -> error response next cycle, busy for exactly one cycle.
        req(32'hFFFF_0000, 1'b1, 4'b0000);
        #3; chk("t4_gnt", bus.per_slave_gnt_o, 1'b1); chk("t4_busy0", busy, 1'b0);
        chk("t4_req", bus.per_master_req_o, 4'b0000);
        tick(); idle_inputs();
        #3; chk("t4_rv", bus.per_slave_r_valid_o, 1'b1); chk("t4_opc", bus.per_slave_r_opc_o, 1'b1);
        chk("t4_rdata", bus.per_slave_r_rdata_o, 32'h0); chk("t4_busy1", busy, 1'b1);
        tick();
        #3; chk("t4_rv_end", bus.per_slave_r_valid_o, 1'b0); chk("t4_busy2", busy, 1'b0);
        tick();

        // 5: reset with two outstanding; late responses are dropped.
        req(32'h2000_0000, 1'b1, 4'b1111);
        #3; chk("t5_gnt0", bus.per_slave_gnt_o, 1'b1);
        tick(); req(32'h2000_0004, 1'b1, 4'b1111);
        #3; chk("t5_gnt1", bus.per_slave_gnt_o, 1'b1);
        tick(); idle_inputs(); rst = 1'b1;
        #3; chk("t5_busy_rst", busy, 1'b0);
        tick(); rst = 1'b0; bus.per_master_r_valid_i = 4'b0100; bus.per_master_r_rdata_i[2] = 32'h1234_5678;
        #3; chk("t5_late_rv", bus.per_slave_r_valid_o, 1'b0); chk("t5_busy", busy, 1'b0);
        tick();
        #3; chk("t5_late_rv2", bus.per_slave_r_valid_o, 1'b0);
        tick(); idle_inputs();
        tick();

        // Table: single request from idle, then its response (if accepted) drains it.
        for (int k = 0; k < 9; k++) begin
            req(tbl[k].addr, 1'b1, tbl[k].gnt_in);
            #3; chk("tbl_req", bus.per_master_req_o, tbl[k].exp_req);
            chk("tbl_gnt", bus.per_slave_gnt_o, tbl[k].exp_gnt);
            tick(); idle_inputs();
            for (int s = 0; s < NB; s++) bus.per_master_r_rdata_i[s] = 32'hA000_0000 + 32'(s);
            if (tbl[k].exp_gnt && !tbl[k].exp_err) bus.per_master_r_valid_i = tbl[k].exp_req;
            #3;
            if (tbl[k].exp_err) begin
                chk("tbl_err_rv", bus.per_slave_r_valid_o, 1'b1);
                chk("tbl_err_opc", bus.per_slave_r_opc_o, 1'b1);
                chk("tbl_err_rdata", bus.per_slave_r_rdata_o, 32'h0);
            end else if (tbl[k].exp_gnt) begin
                chk("tbl_rv", bus.per_slave_r_valid_o, 1'b1);
                chk("tbl_rdata", bus.per_slave_r_rdata_o, 32'hA000_0000 + 32'($clog2(tbl[k].exp_req)));
            end else begin
                chk("tbl_norv", bus.per_slave_r_valid_o, 1'b0);
            end
            tick(); idle_inputs();
            #3; chk("tbl_idle", busy, 1'b0);
            tick();
        end

        // Random traffic against the queue model; slaves answer granted requests after 1-4 cycles.
        err_m = 1'b0; held = 1'b0; held_addr = '0; held_we = 1'b1; r = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!held && $urandom_range(0, 3) != 0) begin
                held = 1'b1;
                if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 4);
                held_addr = (32'(r) << 28) | ($urandom() & 32'h0FFF_FFFF);
                held_we = 1'($urandom_range(0, 1));
            end
            bus.per_slave_req_i   = held;
            bus.per_slave_add_i   = held_addr;
            bus.per_slave_we_ni   = held_we;
            bus.per_slave_wdata_i = $urandom();
            bus.per_slave_be_i    = 4'($urandom());
            for (int s = 0; s < NB; s++) begin
                bus.per_master_gnt_i[s]     = ($urandom_range(0, 3) != 0);
                bus.per_master_r_valid_i[s] = (slq[s].size() > 0) && (slq[s][0] <= cyc);
                bus.per_master_r_opc_i[s]   = 1'($urandom_range(0, 1));
                bus.per_master_r_rdata_i[s] = $urandom();
            end
            #3;
            m = ref_dec(held_addr, t);
            ereq = 4'b0000; egnt = 1'b0;
            if (held && m) begin
                if (!err_m && (inflight.size() == 0 ||
                               (t == inflight[$] && inflight.size() < MAX))) begin
                    ereq[t] = 1'b1;
                    egnt = bus.per_master_gnt_i[t];
                end
            end else if (held && inflight.size() == 0 && !err_m) begin
                egnt = 1'b1;
            end
            erv = 1'b0; eopc = 1'b0; erd = 32'h0;
            if (err_m) begin
                erv = 1'b1; eopc = 1'b1;
            end else if (inflight.size() > 0 && bus.per_master_r_valid_i[inflight[0]]) begin
                erv = 1'b1;
                eopc = bus.per_master_r_opc_i[inflight[0]];
                erd = bus.per_master_r_rdata_i[inflight[0]];
            end
            chk("rnd_gnt", bus.per_slave_gnt_o, egnt);
            chk("rnd_req", bus.per_master_req_o, ereq);
            chk("rnd_rv", bus.per_slave_r_valid_o, erv);
            chk("rnd_busy", busy, (inflight.size() > 0) || err_m);
            if (erv) begin
                chk("rnd_opc", bus.per_slave_r_opc_o, eopc);
                chk("rnd_rdata", bus.per_slave_r_rdata_o, erd);
            end
            nerr = held && !m && egnt;
            if (!err_m && inflight.size() > 0 && bus.per_master_r_valid_i[inflight[0]])
                void'(inflight.pop_front());
            for (int s = 0; s < NB; s++)
                if (bus.per_master_r_valid_i[s]) void'(slq[s].pop_front());
            if (held && m && egnt) begin
                inflight.push_back(t);
                slq[t].push_back(cyc + $urandom_range(1, 4));
            end
            err_m = nerr;
            if (egnt) held = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
